spi_reg_ctrl: RTL and testbench

Register-access controller that sequences `spi_serdes` and turns SPI frames from the host into register-bank reads and writes. It sits between the `spi_serdes` parallel side (`rxShiftReg`, `dataReady`, `txData`, `load`) and the mixer's parameter register bank. It decodes a command byte and an address byte, then streams auto-incrementing data bytes in either direction. It also pre-loads every outgoing MISO byte.

---
 rtl/spi_ctrl_pkg.sv | 18 +
 rtl/spi_reg_ctrl_if.sv | 28 ++
 rtl/ssel_sync.sv | 19 +
 rtl/spi_reg_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and bit positions for the SPI register-access controller
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA
    } spi_ctrl_state_t;

    // Bit positions within an 8-bit command / status byte
    localparam int CMD_RW_BIT     = 7;
    localparam int CMD_CLR_BIT    = 6;
    localparam int STATUS_ERR_BIT = 7;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - serdes parallel side and register-bank port of the controller
interface spi_reg_ctrl_if #(
    parameter int PACKET_WIDTH = 8,
    parameter int ADDR_WIDTH   = 8
);
    logic [PACKET_WIDTH-1:0] rxShiftReg;
    logic                    dataReady;
    logic [PACKET_WIDTH-1:0] txData;
    logic                    load;
    logic [ADDR_WIDTH-1:0]   regAddr;
    logic [PACKET_WIDTH-1:0] regWrData;
    logic                    regWrEn;
    logic                    regRdEn;
    logic [PACKET_WIDTH-1:0] regRdData;
    logic                    regRdValid;
    logic                    busy;
    logic                    errSticky;

    modport master (
        input  rxShiftReg, dataReady, regRdData, regRdValid,
        output txData, load, regAddr, regWrData, regWrEn, regRdEn, busy, errSticky
    );

    modport slave (
        output rxShiftReg, dataReady, regRdData, regRdValid,
        input  txData, load, regAddr, regWrData, regWrEn, regRdEn, busy, errSticky
    );
endinterface

// File: rtl/ssel_sync.sv
// rtl/ssel_sync.sv - two-flop synchronizer for slave select, resets to deselected
module ssel_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ssel_raw,
    output logic ssel_s
);
    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b1;
            ssel_s <= 1'b1;
        end else begin
            meta   <= ssel_raw;
            ssel_s <= meta;
        end
    end
endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - decodes SPI command/address/data frames into register-bank reads and writes
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int                    PACKET_WIDTH = 8,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    MAX_RD_LAT   = 4,
    parameter logic [PACKET_WIDTH-1:0] ERR_BYTE   = 8'hEE
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           spi_SSEL,
    spi_reg_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(MAX_RD_LAT + 1);

    spi_ctrl_state_t         state, state_n;
    logic                    ssel_s, ssel_d;
    logic [PACKET_WIDTH-1:0] tx_q, tx_n;
    logic                    load_q, load_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [PACKET_WIDTH-1:0] wr_data_q, wr_data_n;
    logic                    wr_en_q, wr_en_n;
    logic                    rd_en_q, rd_en_n;
    logic                    err_q, err_n;
    logic                    rw_q, rw_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic                    ssel_fall;

    ssel_sync u_ssel_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .ssel_raw (spi_SSEL),
        .ssel_s   (ssel_s)
    );

    assign ssel_fall = ssel_d & ~ssel_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ssel_d    <= 1'b1;
            tx_q      <= '0;
            load_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
            rw_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            ssel_d    <= ssel_s;
            tx_q      <= tx_n;
            load_q    <= load_n;
            addr_q    <= addr_n;
            wr_data_q <= wr_data_n;
            wr_en_q   <= wr_en_n;
            rd_en_q   <= rd_en_n;
            err_q     <= err_n;
            rw_q      <= rw_n;
            cnt_q     <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        tx_n      = tx_q;
        load_n    = 1'b0;
        addr_n    = addr_q;
        wr_data_n = wr_data_q;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        err_n     = err_q;
        rw_n      = rw_q;
        cnt_n     = cnt_q;

        // Write address advances the cycle after its strobe
        if (wr_en_q) addr_n = addr_q + 1'b1;

        case (state)
            ST_IDLE: begin
                if (ssel_fall) begin
                    tx_n                 = '0;
                    tx_n[STATUS_ERR_BIT] = err_q;
                    load_n               = 1'b1;
                    state_n              = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.dataReady) begin
                    rw_n = bus.rxShiftReg[CMD_RW_BIT];
                    if (bus.rxShiftReg[CMD_CLR_BIT]) err_n = 1'b0;
                    tx_n    = '0;
                    load_n  = 1'b1;
                    state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.dataReady) begin
                    addr_n = bus.rxShiftReg[ADDR_WIDTH-1:0];
                    if (rw_q) begin
                        tx_n    = '0;
                        load_n  = 1'b1;
                        state_n = ST_WDATA;
                    end else begin
                        rd_en_n = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_RWAIT;
                    end
                end
            end
            ST_WDATA: begin
                if (bus.dataReady) begin
                    wr_en_n   = 1'b1;
                    wr_data_n = bus.rxShiftReg;
                    tx_n      = '0;
                    load_n    = 1'b1;
                end
            end
            ST_RWAIT: begin
                if (bus.regRdValid) begin
                    tx_n    = bus.regRdData;
                    load_n  = 1'b1;
                    state_n = ST_RDATA;
                end else if (cnt_q == CNT_W'(MAX_RD_LAT)) begin
                    tx_n    = ERR_BYTE;
                    load_n  = 1'b1;
                    err_n   = 1'b1;
                    state_n = ST_RDATA;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_RDATA: begin
                if (bus.dataReady) begin
                    addr_n  = addr_q + 1'b1;
                    rd_en_n = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_RWAIT;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Deselect wins over everything except a write already decoded this cycle
        if (ssel_s && state != ST_IDLE) begin
            state_n = ST_IDLE;
            load_n  = 1'b0;
            rd_en_n = 1'b0;
        end
    end

    assign bus.txData    = tx_q;
    assign bus.load      = load_q;
    assign bus.regAddr   = addr_q;
    assign bus.regWrData = wr_data_q;
    assign bus.regWrEn   = wr_en_q;
    assign bus.regRdEn   = rd_en_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.errSticky = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - randomized self-checking bench for spi_reg_ctrl against a frame-level model
module tb_spi_reg_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    logic spi_SSEL;
    logic resp_valid, manual_valid;
    logic [7:0] resp_data;
    int rd_lat;
    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  bank [256];
    logic [7:0]  frame_data [$];
    logic [7:0]  act_miso [$], exp_miso [$];
    logic [15:0] act_wr [$], exp_wr [$];
    logic [7:0]  act_rd [$], exp_rd [$];
    logic        model_err;

    always #5 clk = ~clk;

    spi_reg_ctrl_if #(.PACKET_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    assign bus.regRdValid = resp_valid | manual_valid;
    assign bus.regRdData  = resp_data;

    spi_reg_ctrl #(.PACKET_WIDTH(8), .ADDR_WIDTH(8), .MAX_RD_LAT(4), .ERR_BYTE(8'hEE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_SSEL (spi_SSEL),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register bank: answers each read strobe after rd_lat cycles; rd_lat 0 means never
    initial begin
        logic [7:0] a;
        resp_valid = 1'b0;
        resp_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.regRdEn && rd_lat > 0) begin
                a = bus.regAddr;
                repeat (rd_lat) @(posedge clk);
                #1;
                resp_valid = 1'b1;
                resp_data  = bank[a];
                @(posedge clk); #1;
                resp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.load)    act_miso.push_back(bus.txData);
            if (bus.regWrEn) act_wr.push_back({bus.regAddr, bus.regWrData});
            if (bus.regRdEn) act_rd.push_back(bus.regAddr);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat (14 + $urandom_range(0, 6)) @(posedge clk);
        #1;
        bus.rxShiftReg = b;
        bus.dataReady  = 1'b1;
        @(posedge clk); #1;
        bus.dataReady  = 1'b0;
    endtask

    task automatic start_frame();
        act_miso.delete(); act_wr.delete(); act_rd.delete();
        spi_SSEL = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        repeat (16) @(posedge clk);
        #1 spi_SSEL = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int lat);
        int n = frame_data.size();
        logic [7:0] a;
        exp_miso.delete(); exp_wr.delete(); exp_rd.delete();
        exp_miso.push_back(model_err ? 8'h80 : 8'h00);
        exp_miso.push_back(8'h00);
        if (cmd[6]) model_err = 1'b0;
        if (cmd[7]) begin
            exp_miso.push_back(8'h00);
            for (int i = 0; i < n; i++) begin
                a = 8'(addr + i);
                exp_wr.push_back({a, frame_data[i]});
                exp_miso.push_back(8'h00);
            end
        end else begin
            for (int i = 0; i <= n; i++) begin
                a = 8'(addr + i);
                exp_rd.push_back(a);
                if (lat == 0) begin
                    exp_miso.push_back(8'hEE);
                    model_err = 1'b1;
                end else begin
                    exp_miso.push_back(bank[a]);
                end
            end
        end

        rd_lat = lat;
        start_frame();
        send_byte(cmd);
        send_byte(addr);
        foreach (frame_data[i]) send_byte(frame_data[i]);
        end_frame();

        check("miso_count", act_miso.size(), exp_miso.size());
        for (int i = 0; i < act_miso.size() && i < exp_miso.size(); i++)
            check($sformatf("miso[%0d] cmd=%h", i, cmd), act_miso[i], exp_miso[i]);
        check("wr_count", act_wr.size(), exp_wr.size());
        for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
            check($sformatf("wr[%0d]", i), act_wr[i], exp_wr[i]);
        check("rd_count", act_rd.size(), exp_rd.size());
        for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++)
            check($sformatf("rd[%0d]", i), act_rd[i], exp_rd[i]);
        check("err_sticky", bus.errSticky, model_err);
        check("busy_after", bus.busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txData"},    bus.txData, 8'h00);
        check({tag, "_load"},      bus.load, 1'b0);
        check({tag, "_regAddr"},   bus.regAddr, 8'h00);
        check({tag, "_regWrData"}, bus.regWrData, 8'h00);
        check({tag, "_regWrEn"},   bus.regWrEn, 1'b0);
        check({tag, "_regRdEn"},   bus.regRdEn, 1'b0);
        check({tag, "_busy"},      bus.busy, 1'b0);
        check({tag, "_errSticky"}, bus.errSticky, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cmd, addr;
        int lat, n;
        reset_n = 1'b0;
        spi_SSEL = 1'b1;
        manual_valid = 1'b0;
        rd_lat = 0;
        bus.rxShiftReg = 8'h00;
        bus.dataReady = 1'b0;
        model_err = 1'b0;
        for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
        bank[8'h20] = 8'h5A;
        bank[8'h21] = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        frame_data = '{8'hAB, 8'hCD};
        run_frame(8'h80, 8'h10, 2);
        check("wb_w1", act_wr.size() > 1 ? act_wr[1] : 16'h0, 16'h11CD);

        frame_data = '{8'h00, 8'h00};
        run_frame(8'h00, 8'h20, 2);
        check("rb_miso3", act_miso.size() > 3 ? act_miso[3] : 8'h0, 8'hA5);
        check("rb_rd2", act_rd.size() > 2 ? act_rd[2] : 8'h0, 8'h22);

        frame_data = '{8'h01, 8'h02};
        run_frame(8'h80, 8'hFF, 1);
        check("wrap_w1", act_wr.size() > 1 ? act_wr[1] : 16'hFFFF, 16'h0002);

        frame_data = '{8'h00};
        run_frame(8'h00, 8'h30, 0);
        check("to_miso2", act_miso.size() > 2 ? act_miso[2] : 8'h0, 8'hEE);

        frame_data = '{8'h3C};
        run_frame(8'h80, 8'h50, 1);
        check("to_status", act_miso.size() > 0 ? act_miso[0] : 8'h0, 8'h80);

        frame_data = '{8'h00};
        run_frame(8'h40, 8'h60, 3);
        check("clr_status", act_miso.size() > 0 ? act_miso[0] : 8'h0, 8'h80);

        // Abort a write after its address byte
        start_frame();
        send_byte(8'h80);
        send_byte(8'h10);
        repeat (2) @(posedge clk);
        #1 spi_SSEL = 1'b1;
        for (int i = 0; i < 3 && bus.busy; i++) begin
            @(posedge clk); #1;
        end
        check("abort_busy", bus.busy, 1'b0);
        send_byte(8'h77);
        repeat (5) @(posedge clk);
        #1;
        check("abort_wr", act_wr.size(), 0);
        check("abort_loads", act_miso.size(), 3);

        frame_data = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h80, 8'h40, 1);

        for (int f = 0; f < 24; f++) begin
            cmd  = 8'($urandom);
            cmd[6] = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 8'(8'hFD + $urandom_range(0, 2)) : 8'($urandom);
            lat  = $urandom_range(0, 4);
            n    = $urandom_range(0, 3);
            frame_data.delete();
            for (int i = 0; i < n; i++) frame_data.push_back(8'($urandom));
            run_frame(cmd, addr, lat);
        end

        // Force errSticky on so the mid-read reset visibly clears it
        frame_data.delete();
        run_frame(8'h00, 8'h70, 0);
        rd_lat = 0;
        start_frame();
        send_byte(8'h00);
        send_byte(8'h30);
        repeat (2) @(posedge clk);
        check("rst_pre_busy", bus.busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_err = 1'b0;
        @(posedge clk); #1 spi_SSEL = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        act_miso.delete();
        manual_valid = 1'b1;
        @(posedge clk); #1 manual_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("late_valid_load", act_miso.size(), 0);
        check("late_valid_busy", bus.busy, 1'b0);

        frame_data = '{8'h9A};
        run_frame(8'h00, 8'h20, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
